// File: rtl/mips_cpu_muldiv_seq.sv
// Iterative HI/LO unit for the MIPS core: 32-step shift-add multiply and
// restoring divide, plus the MTHI/MTLO/MFHI/MFLO moves.
module mips_cpu_muldiv_seq (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic        stall,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] result
);
  typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

  state_t      state_reg;
  logic [31:0] hi_reg, lo_reg;
  logic [31:0] acc_reg;   // running product high half / partial remainder
  logic [31:0] wrk_reg;   // multiplier bits, later product low half / dividend, later quotient
  logic [31:0] opnd_reg;  // multiplicand / divisor magnitude
  logic [5:0]  cnt_reg;
  logic        neg_lo_reg, neg_hi_reg, is_div_reg, done_reg;

  logic        is_signed;
  logic [31:0] a_mag, b_mag;
  logic [32:0] mul_sum, div_shift, div_diff;
  logic [63:0] prod_fix;
  logic [31:0] quo_fix, rem_fix;

  assign is_signed = ~op[0];
  assign a_mag     = (is_signed && a[31]) ? -a : a;
  assign b_mag     = (is_signed && b[31]) ? -b : b;

  assign mul_sum   = {1'b0, acc_reg} + (wrk_reg[0] ? {1'b0, opnd_reg} : 33'd0);
  assign div_shift = {acc_reg, wrk_reg[31]};
  assign div_diff  = div_shift - {1'b0, opnd_reg};

  assign prod_fix  = neg_lo_reg ? -{acc_reg, wrk_reg} : {acc_reg, wrk_reg};
  assign quo_fix   = neg_lo_reg ? -wrk_reg : wrk_reg;
  assign rem_fix   = neg_hi_reg ? -acc_reg : acc_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg  <= IDLE;
      hi_reg     <= 32'd0;
      lo_reg     <= 32'd0;
      acc_reg    <= 32'd0;
      wrk_reg    <= 32'd0;
      opnd_reg   <= 32'd0;
      cnt_reg    <= 6'd0;
      neg_lo_reg <= 1'b0;
      neg_hi_reg <= 1'b0;
      is_div_reg <= 1'b0;
      done_reg   <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start) begin
            case (op)
              3'b000, 3'b001: begin
                acc_reg    <= 32'd0;
                wrk_reg    <= b_mag;
                opnd_reg   <= a_mag;
                cnt_reg    <= 6'd0;
                neg_lo_reg <= is_signed & (a[31] ^ b[31]);
                neg_hi_reg <= 1'b0;
                is_div_reg <= 1'b0;
                state_reg  <= MUL;
              end
              3'b010, 3'b011: begin
                acc_reg    <= 32'd0;
                wrk_reg    <= a_mag;
                opnd_reg   <= b_mag;
                cnt_reg    <= 6'd0;
                // A zero divisor leaves the all-ones quotient uncorrected and the
                // remainder equal to |a|, which re-signs back to a itself.
                neg_lo_reg <= is_signed & (a[31] ^ b[31]) & (b != 32'd0);
                neg_hi_reg <= is_signed & a[31];
                is_div_reg <= 1'b1;
                state_reg  <= DIV;
              end
              3'b100:  hi_reg <= a;
              3'b101:  lo_reg <= a;
              default: ;
            endcase
          end
        end
        MUL: begin
          if (cnt_reg == 6'd32) begin
            state_reg <= FIX;
          end else begin
            acc_reg <= mul_sum[32:1];
            wrk_reg <= {mul_sum[0], wrk_reg[31:1]};
            cnt_reg <= cnt_reg + 6'd1;
          end
        end
        DIV: begin
          if (cnt_reg == 6'd32) begin
            state_reg <= FIX;
          end else begin
            if (!div_diff[32]) begin
              acc_reg <= div_diff[31:0];
              wrk_reg <= {wrk_reg[30:0], 1'b1};
            end else begin
              acc_reg <= div_shift[31:0];
              wrk_reg <= {wrk_reg[30:0], 1'b0};
            end
            cnt_reg <= cnt_reg + 6'd1;
          end
        end
        FIX: begin
          if (is_div_reg) begin
            lo_reg <= quo_fix;
            hi_reg <= rem_fix;
          end else begin
            hi_reg <= prod_fix[63:32];
            lo_reg <= prod_fix[31:0];
          end
          done_reg  <= 1'b1;
          cnt_reg   <= 6'd0;
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign busy   = (state_reg != IDLE);
  assign done   = done_reg;
  assign stall  = start & busy;
  assign hi     = hi_reg;
  assign lo     = lo_reg;
  assign result = (op == 3'b110) ? hi_reg : (op == 3'b111) ? lo_reg : 32'd0;
endmodule

// File: tb/tb_mips_cpu_muldiv_seq.sv
// Self-checking bench for mips_cpu_muldiv_seq: directed and random MULT/DIV
// against a 64-bit arithmetic model, moves, stall behaviour and reset abort.
module tb_mips_cpu_muldiv_seq;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [31:0] a = 32'd0;
  logic [31:0] b = 32'd0;
  logic        busy, done, stall;
  logic [31:0] hi, lo, result;

  int checks = 0;
  int errors = 0;
  logic [31:0] model_hi = 32'd0;
  logic [31:0] model_lo = 32'd0;

  mips_cpu_muldiv_seq dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .stall(stall), .hi(hi), .lo(lo), .result(result)
  );

  always #5 clk = ~clk;

  // Architectural result {hi,lo} computed with plain wide arithmetic.
  function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] x,
                                        input logic [31:0] y);
    longint sx, sy, q, r;
    logic [63:0] ux, uy;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ux = {32'd0, x};
    uy = {32'd0, y};
    case (o)
      3'd0: return sx * sy;
      3'd1: return ux * uy;
      3'd2: begin
        if (y == 32'd0) return {x, 32'hFFFFFFFF};
        q = sx / sy;
        r = sx % sy;
        return {r[31:0], q[31:0]};
      end
      default: begin
        if (y == 32'd0) return {x, 32'hFFFFFFFF};
        return {x % y, x / y};
      end
    endcase
  endfunction

  // Issue one MULT/DIV at a negedge and watch the following 40 cycles.
  task automatic run_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    logic [63:0] exp;
    int busy_cnt, done_cnt, done_at;
    bit held;
    exp = model(o, x, y);
    busy_cnt = 0; done_cnt = 0; done_at = -1; held = 1'b1;
    start = 1'b1; op = o; a = x; b = y;
    @(posedge clk);
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (c == 0) start = 1'b0;
      if (busy) busy_cnt++;
      if (done) begin done_cnt++; done_at = c; end
      if (c < 34 && (hi !== model_hi || lo !== model_lo)) held = 1'b0;
    end
    $display("txn op=%0d a=%h b=%h -> hi=%h lo=%h (want %h %h)", o, x, y, hi, lo,
             exp[63:32], exp[31:0]);
    checks++;
    if (busy_cnt !== 34) begin errors++; $display("FAIL busy_len: got %0d expected 34", busy_cnt); end
    checks++;
    if (done_cnt !== 1 || done_at !== 34) begin
      errors++; $display("FAIL done_pulse: got count %0d at %0d expected 1 at 34", done_cnt, done_at);
    end
    checks++;
    if (!held) begin errors++; $display("FAIL hilo_hold: hi/lo changed before result write"); end
    checks++;
    if (hi !== exp[63:32]) begin errors++; $display("FAIL hi: got %h expected %h", hi, exp[63:32]); end
    checks++;
    if (lo !== exp[31:0]) begin errors++; $display("FAIL lo: got %h expected %h", lo, exp[31:0]); end
    model_hi = exp[63:32];
    model_lo = exp[31:0];
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if (hi !== 32'd0 || lo !== 32'd0 || busy !== 1'b0 || done !== 1'b0 || stall !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: got hi=%h lo=%h busy=%b done=%b stall=%b expected all 0",
               hi, lo, busy, done, stall);
    end
    reset = 1'b1;
    run_op(3'd0, 32'hFFFFFFFD, 32'd7);  // accepted on first edge after reset
  endtask

  task automatic test_directed();
    run_op(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF);
    run_op(3'd2, 32'hFFFFFFF9, 32'd2);
    run_op(3'd3, 32'd7, 32'd0);
    run_op(3'd2, 32'h80000000, 32'hFFFFFFFF);
    run_op(3'd2, 32'hFFFFFFFB, 32'd0);
    run_op(3'd0, 32'h80000000, 32'h80000000);
    run_op(3'd3, 32'hFFFFFFFF, 32'd1);
  endtask

  task automatic test_random();
    logic [31:0] x, y;
    logic [2:0]  o;
    for (int i = 0; i < 20; i++) begin
      o = 3'($urandom_range(0, 3));
      x = $urandom;
      y = (i % 5 == 4) ? 32'd0 : ((i % 3 == 0) ? 32'($urandom_range(1, 50)) : $urandom);
      run_op(o, x, y);
    end
  endtask

  task automatic test_move();
    start = 1'b1; op = 3'b100; a = 32'h12345678;
    @(posedge clk); #1;
    model_hi = 32'h12345678;
    $display("txn MTHI a=12345678 -> hi=%h busy=%b done=%b", hi, busy, done);
    checks++;
    if (hi !== model_hi || busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL mthi: got hi=%h busy=%b done=%b expected 12345678 0 0", hi, busy, done);
    end
    @(negedge clk);
    op = 3'b101; a = 32'hCAFEF00D;
    @(posedge clk); #1;
    model_lo = 32'hCAFEF00D;
    $display("txn MTLO a=cafef00d -> lo=%h", lo);
    checks++;
    if (lo !== model_lo || hi !== model_hi || done !== 1'b0) begin
      errors++; $display("FAIL mtlo: got hi=%h lo=%h done=%b expected %h %h 0", hi, lo, done, model_hi, model_lo);
    end
    @(negedge clk);
    op = 3'b110; a = 32'hDEADBEEF; #1;
    $display("txn MFHI -> result=%h stall=%b", result, stall);
    checks++;
    if (result !== model_hi || stall !== 1'b0) begin
      errors++; $display("FAIL mfhi: got %h stall=%b expected %h 0", result, stall, model_hi);
    end
    op = 3'b111; #1;
    $display("txn MFLO -> result=%h stall=%b", result, stall);
    checks++;
    if (result !== model_lo || stall !== 1'b0) begin
      errors++; $display("FAIL mflo: got %h stall=%b expected %h 0", result, stall, model_lo);
    end
    @(posedge clk); #1;
    checks++;
    if (hi !== model_hi || lo !== model_lo || busy !== 1'b0) begin
      errors++; $display("FAIL mf_nowrite: got hi=%h lo=%h busy=%b expected %h %h 0", hi, lo, busy, model_hi, model_lo);
    end
    @(negedge clk);
    start = 1'b0; op = 3'b000; #1;
    checks++;
    if (result !== 32'd0) begin errors++; $display("FAIL result_other: got %h expected 0", result); end
  endtask

  // MULT, a stray MTHI while busy, then MFLO held from cycle 5 until stall drops.
  task automatic test_stall();
    logic [31:0] x, y;
    logic [63:0] exp;
    bit stall_ok, held, seen_free;
    x = $urandom; y = $urandom;
    exp = model(3'd0, x, y);
    stall_ok = 1'b1; held = 1'b1; seen_free = 1'b0;
    start = 1'b1; op = 3'd0; a = x; b = y;
    @(posedge clk);
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (c == 0) start = 1'b0;
      if (c == 2) begin start = 1'b1; op = 3'b100; a = $urandom; b = $urandom; end
      if (c == 3) start = 1'b0;
      if (c >= 5) begin start = 1'b1; op = 3'b111; end
      #1;
      if (c < 34 && (hi !== model_hi || lo !== model_lo)) held = 1'b0;
      if ((c == 2 || (c >= 5 && busy)) && stall !== 1'b1) stall_ok = 1'b0;
      if (c >= 5 && !busy && !seen_free) begin
        seen_free = 1'b1;
        $display("txn MFLO after MULT a=%h b=%h -> result=%h stall=%b at cycle %0d", x, y, result, stall, c);
        checks++;
        if (c !== 34 || stall !== 1'b0 || result !== exp[31:0]) begin
          errors++;
          $display("FAIL mflo_after_stall: got cycle %0d stall=%b result=%h expected 34 0 %h",
                   c, stall, result, exp[31:0]);
        end
      end
    end
    start = 1'b0;
    checks++;
    if (!stall_ok) begin errors++; $display("FAIL stall_while_busy: stall was low during busy request"); end
    checks++;
    if (!held) begin errors++; $display("FAIL busy_ignore: hi/lo changed during MULT"); end
    checks++;
    if (!seen_free) begin errors++; $display("FAIL stall_timeout: busy never dropped"); end
    checks++;
    if (hi !== exp[63:32]) begin errors++; $display("FAIL stall_hi: got %h expected %h", hi, exp[63:32]); end
    model_hi = exp[63:32];
    model_lo = exp[31:0];
  endtask

  task automatic test_reset_mid();
    bit quiet;
    quiet = 1'b1;
    start = 1'b1; op = 3'd2; a = 32'hFFFFFF9C; b = 32'd7;
    @(posedge clk);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (c == 0) start = 1'b0;
    end
    #2 reset = 1'b0;
    #1;
    model_hi = 32'd0;
    model_lo = 32'd0;
    $display("txn reset mid-DIV -> hi=%h lo=%h busy=%b done=%b", hi, lo, busy, done);
    checks++;
    if (hi !== 32'd0 || lo !== 32'd0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL reset_abort: got hi=%h lo=%h busy=%b done=%b expected 0 0 0 0", hi, lo, busy, done);
    end
    @(negedge clk);
    reset = 1'b1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (done || busy || hi !== 32'd0 || lo !== 32'd0) quiet = 1'b0;
    end
    checks++;
    if (!quiet) begin errors++; $display("FAIL reset_discard: aborted DIV resurfaced"); end
    run_op(3'd0, 32'd12, 32'hFFFFFFFE);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_move();
    test_stall();
    test_random();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
